wb_multi_counter_regs: RTL
==========================

// Module: wb_multi_counter_regs
// PURPOSE
//  Parametrised multi-channel counter register block on the FPGA Wishbone slave bus.
//  Sits in the FPGA register aperture beside the QL reserved block and replaces the single 32-bit counter register set.
//  Provides NUM_CNT independent up/down counters with load, compare, wrap detection, sticky status and an interrupt.
// PARAMETERS
//  ADDRWIDTH      7             word-address width of WBs_ADR_i
//  DATAWIDTH      32            bus data width (fixed 32)
//  NUM_CNT        4             counter channels, 1..16
//  CNT_WIDTH      32            counter width, 1..32
//  DEVICE_ID      16'h0         value of ID register [15:0] and Device_ID_o
//  REV_LEVEL      32'h0         value of REV register
//  DEF_REG_VALUE  32'hFAB_DEF_AC read value of any unmapped address
// PORTS
//  WB_CLK        in   1                  bus/counter clock
//  WB_RST_N      in   1                  reset; one clock; reset is asynchronous and active-low
//  WBs_ADR_i     in   ADDRWIDTH          word address
//  WBs_CYC_i     in   1                  cycle select (already decoded for this aperture)
//  WBs_STB_i     in   1                  strobe
//  WBs_WE_i      in   1                  1=write, 0=read
//  WBs_BYTE_STB_i in  4                  byte enables for writes
//  WBs_DAT_i     in   32                 write data
//  WBs_DAT_o     out  32                 read data, valid while WBs_ACK_o=1
//  WBs_ACK_o     out  1                  transfer acknowledge
//  count_o       out  NUM_CNT*CNT_WIDTH  live counter values, ch0 in LSBs
//  irq_o         out  1                  |(STATUS & IRQ_EN)
//  Device_ID_o   out  32                 {16'h0, DEVICE_ID}
// BEHAVIOUR
//  Reset: WBs_ACK_o=0, WBs_DAT_o=0, irq_o=0, all counters/CTRL/LOAD/STATUS/IRQ_EN=0, COMPARE=all-ones.
//  Handshake: ACK registered; rises one cycle after CYC&STB&~ACK, high exactly 1 cycle; next access needs STB re-qualified
//   (no double ACK). Write commits on ACK-asserting edge; read data = register value sampled on that edge.
//  Byte strobes honoured on all writable regs; bits >= CNT_WIDTH ignored on write, read as 0.
//  Map (word addr): 0x00 ID RO; 0x01 REV RO; 0x02 STATUS W1C: [ch]=wrap, [16+ch]=match;
//   0x03 IRQ_EN RW same layout; channel c at 0x10+4c: +0 CTRL RW, +1 LOAD RW, +2 COMPARE RW, +3 VALUE RO.
//   Unmapped or c>=NUM_CNT -> read DEF_REG_VALUE, writes ignored, still ACKed.
//  CTRL bits: [0] EN, [1] DOWN, [2] AUTO_RELOAD, [3] LOAD_STB (write-1 pulse, reads 0).
//  Per-channel update each clock, priority high->low:
//   1 LOAD_STB written: cnt<=LOAD next edge (counting suppressed that cycle).
//   2 EN&~DOWN: cnt==max ? (AUTO_RELOAD ? LOAD : 0), set wrap : cnt+1.
//   3 EN&DOWN:  cnt==0   ? (AUTO_RELOAD ? LOAD : max), set wrap : cnt-1.
//   4 else hold. Arithmetic modulo 2^CNT_WIDTH.
//  Match: set when cnt updates (by count or load) to a value equal to COMPARE; holding at COMPARE does not re-set.
//  STATUS: set and W1C on same bit same cycle -> set wins. Wrap and match may set in same cycle.
//  irq_o combinational from registered STATUS/IRQ_EN (asserts cycle after flag sets).
//  Async reset mid-transfer: ACK drops immediately; host must retry; no partial write retained.
// TESTING
//  1 Reset; read 0x00,0x01,0x7F -> {16'h0,DEVICE_ID}, REV_LEVEL, 32'hFAB_DEF_AC; ACK 1 cycle each.
//  2 ch0 CTRL=1, run 10 clk, read VALUE -> 10 (+/-pipeline 1, checked exact vs model); EN=0 then value frozen.
//  3 CNT_WIDTH=8: LOAD=0xFE, CTRL=0xD (load+en+auto) -> FE,FF,FE..; STATUS[0]=1; IRQ_EN[0]=1 -> irq_o=1; W1C 0x1 -> irq_o=0.
//  4 DOWN from 0, AUTO_RELOAD=0 -> wraps to 0xFF, wrap flag set; COMPARE=0xFC -> match bit16 set after 3 more clocks.
//  5 W1C on STATUS in same cycle as new wrap -> bit remains 1; BYTE_STB=4'b0001 write to LOAD -> only [7:0] change.
//  6 Assert WB_RST_N=0 mid-ACK and mid-count -> all outputs 0 asynchronously; channel NUM_CNT address reads DEF_REG_VALUE.

Source files
------------

// File: rtl/wb_multi_counter_regs_if.sv
// Wishbone slave bus bundle for the multi-channel counter register block.
// Signal names keep the aperture's _i/_o naming as seen from the slave.
interface wb_multi_counter_regs_if #(
  parameter int unsigned ADDRWIDTH = 7
);
  logic [ADDRWIDTH-1:0] WBs_ADR_i;
  logic                 WBs_CYC_i;
  logic                 WBs_STB_i;
  logic                 WBs_WE_i;
  logic [3:0]           WBs_BYTE_STB_i;
  logic [31:0]          WBs_DAT_i;
  logic [31:0]          WBs_DAT_o;
  logic                 WBs_ACK_o;

  modport slave (
    input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    output WBs_DAT_o, WBs_ACK_o
  );

  modport master (
    output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
    input  WBs_DAT_o, WBs_ACK_o
  );
endinterface

// File: rtl/wb_multi_counter_regs.sv
// NUM_CNT up/down counters with load, compare, wrap detection, sticky W1C status
// and a level interrupt, mapped into the FPGA Wishbone register aperture.
module wb_multi_counter_regs #(
  parameter int unsigned ADDRWIDTH     = 7,
  parameter int unsigned DATAWIDTH     = 32,
  parameter int unsigned NUM_CNT       = 4,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter logic [15:0] DEVICE_ID     = 16'h0,
  parameter logic [31:0] REV_LEVEL     = 32'h0,
  parameter logic [31:0] DEF_REG_VALUE = 32'hFABDEFAC
) (
  input  logic                          WB_CLK,
  input  logic                          WB_RST_N,
  wb_multi_counter_regs_if.slave        wb,
  output logic [NUM_CNT*CNT_WIDTH-1:0]  count_o,
  output logic                          irq_o,
  output logic [31:0]                   Device_ID_o
);

  localparam int unsigned     MATCH_LSB = 16;
  localparam int unsigned     CHAN_BASE = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [ADDRWIDTH-1:0] ADR_ID     = ADDRWIDTH'(0);
  localparam logic [ADDRWIDTH-1:0] ADR_REV    = ADDRWIDTH'(1);
  localparam logic [ADDRWIDTH-1:0] ADR_STATUS = ADDRWIDTH'(2);
  localparam logic [ADDRWIDTH-1:0] ADR_IRQEN  = ADDRWIDTH'(3);

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_LOAD  = 2'd1;
  localparam logic [1:0] OFF_CMP   = 2'd2;
  localparam logic [1:0] OFF_VALUE = 2'd3;

  // CTRL storage bits (LOAD_STB at bit 3 is a pulse and is not stored)
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_DOWN = 1;
  localparam int unsigned CTRL_AUTO = 2;
  localparam int unsigned CTRL_LDS  = 3;

  logic                 ack_q;
  logic [DATAWIDTH-1:0] rdat_q, rdat_d;

  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d  [NUM_CNT];
  logic [CNT_WIDTH-1:0] load_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] load_d [NUM_CNT];
  logic [CNT_WIDTH-1:0] cmp_q  [NUM_CNT];
  logic [CNT_WIDTH-1:0] cmp_d  [NUM_CNT];
  logic [2:0]           ctrl_q [NUM_CNT];
  logic [2:0]           ctrl_d [NUM_CNT];

  logic [NUM_CNT-1:0] wrap_q, wrap_d, match_q, match_d;
  logic [NUM_CNT-1:0] ien_wrap_q, ien_wrap_d, ien_match_q, ien_match_d;
  logic [NUM_CNT-1:0] wrap_set_c, match_set_c, ld_stb_c;

  logic [ADDRWIDTH-1:0] adr;
  logic [ADDRWIDTH-1:0] chan_c;
  logic [1:0]           off_c;
  logic                 in_chan_c;
  logic                 access_c;
  logic                 wr_c;
  logic [31:0]          wmask_c;
  logic [31:0]          status_word_c;
  logic [31:0]          ien_word_c;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] mask,
                                           input logic [31:0] new_v);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  assign adr      = wb.WBs_ADR_i;
  assign access_c = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
  assign wr_c     = access_c & wb.WBs_WE_i;
  assign wmask_c  = {{8{wb.WBs_BYTE_STB_i[3]}}, {8{wb.WBs_BYTE_STB_i[2]}},
                     {8{wb.WBs_BYTE_STB_i[1]}}, {8{wb.WBs_BYTE_STB_i[0]}}};

  assign wb.WBs_ACK_o = ack_q;
  assign wb.WBs_DAT_o = 32'(rdat_q);
  assign Device_ID_o  = {16'h0, DEVICE_ID};

  // Channel window decode: four words per channel starting at CHAN_BASE
  always_comb begin
    chan_c    = (adr - ADDRWIDTH'(CHAN_BASE)) >> 2;
    off_c     = adr[1:0];
    in_chan_c = (adr >= ADDRWIDTH'(CHAN_BASE)) && (32'(chan_c) < NUM_CNT);
  end

  always_comb begin
    status_word_c = '0;
    ien_word_c    = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      status_word_c[c]             = wrap_q[c];
      status_word_c[MATCH_LSB + c] = match_q[c];
      ien_word_c[c]                = ien_wrap_q[c];
      ien_word_c[MATCH_LSB + c]    = ien_match_q[c];
    end
  end

  // Register writes for the per-channel CTRL/LOAD/COMPARE words
  always_comb begin : p_chan_wr
    logic [31:0] merged;
    merged   = '0;
    ld_stb_c = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      ctrl_d[c] = ctrl_q[c];
      load_d[c] = load_q[c];
      cmp_d[c]  = cmp_q[c];
      if (wr_c && in_chan_c && (chan_c == ADDRWIDTH'(c))) begin
        case (off_c)
          OFF_CTRL: begin
            merged      = be_merge(32'(ctrl_q[c]), wmask_c, wb.WBs_DAT_i);
            ctrl_d[c]   = merged[2:0];
            ld_stb_c[c] = wb.WBs_BYTE_STB_i[0] & wb.WBs_DAT_i[CTRL_LDS];
          end
          OFF_LOAD: begin
            merged    = be_merge(32'(load_q[c]), wmask_c, wb.WBs_DAT_i);
            load_d[c] = merged[CNT_WIDTH-1:0];
          end
          OFF_CMP: begin
            merged   = be_merge(32'(cmp_q[c]), wmask_c, wb.WBs_DAT_i);
            cmp_d[c] = merged[CNT_WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Counter update: load strobe beats counting; match only on an actual update
  always_comb begin : p_count
    logic upd;
    upd         = 1'b0;
    wrap_set_c  = '0;
    match_set_c = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      cnt_d[c] = cnt_q[c];
      upd      = 1'b0;
      if (ld_stb_c[c]) begin
        cnt_d[c] = load_q[c];
        upd      = 1'b1;
      end else if (ctrl_q[c][CTRL_EN]) begin
        upd = 1'b1;
        if (!ctrl_q[c][CTRL_DOWN]) begin
          if (cnt_q[c] == CNT_MAX) begin
            cnt_d[c]      = ctrl_q[c][CTRL_AUTO] ? load_q[c] : '0;
            wrap_set_c[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
          end
        end else begin
          if (cnt_q[c] == '0) begin
            cnt_d[c]      = ctrl_q[c][CTRL_AUTO] ? load_q[c] : CNT_MAX;
            wrap_set_c[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] - CNT_WIDTH'(1);
          end
        end
      end
      match_set_c[c] = upd && (cnt_d[c] == cmp_q[c]);
    end
  end

  // Sticky status: a new event in the same cycle as its W1C keeps the bit set
  always_comb begin : p_status
    logic [31:0] w1c;
    logic [31:0] ien_new;
    w1c     = (wr_c && (adr == ADR_STATUS)) ? (wb.WBs_DAT_i & wmask_c) : '0;
    ien_new = (wr_c && (adr == ADR_IRQEN))
              ? be_merge(ien_word_c, wmask_c, wb.WBs_DAT_i) : ien_word_c;
    wrap_d      = '0;
    match_d     = '0;
    ien_wrap_d  = '0;
    ien_match_d = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      wrap_d[c]      = (wrap_q[c]  & ~w1c[c])             | wrap_set_c[c];
      match_d[c]     = (match_q[c] & ~w1c[MATCH_LSB + c]) | match_set_c[c];
      ien_wrap_d[c]  = ien_new[c];
      ien_match_d[c] = ien_new[MATCH_LSB + c];
    end
  end

  // Read mux, captured on the ACK-asserting edge
  always_comb begin : p_read
    logic [31:0] rv;
    rv = DEF_REG_VALUE;
    if (adr == ADR_ID) begin
      rv = {16'h0, DEVICE_ID};
    end else if (adr == ADR_REV) begin
      rv = REV_LEVEL;
    end else if (adr == ADR_STATUS) begin
      rv = status_word_c;
    end else if (adr == ADR_IRQEN) begin
      rv = ien_word_c;
    end else if (in_chan_c) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        if (chan_c == ADDRWIDTH'(c)) begin
          case (off_c)
            OFF_CTRL:  rv = 32'(ctrl_q[c]);
            OFF_LOAD:  rv = 32'(load_q[c]);
            OFF_CMP:   rv = 32'(cmp_q[c]);
            OFF_VALUE: rv = 32'(cnt_q[c]);
            default:   rv = DEF_REG_VALUE;
          endcase
        end
      end
    end
    rdat_d = (access_c && !wb.WBs_WE_i) ? DATAWIDTH'(rv) : '0;
  end

  always_comb begin
    count_o = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      count_o[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
    end
  end

  assign irq_o = |((wrap_q & ien_wrap_q) | (match_q & ien_match_q));

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      wrap_q      <= '0;
      match_q     <= '0;
      ien_wrap_q  <= '0;
      ien_match_q <= '0;
      for (int c = 0; c < NUM_CNT; c++) begin
        cnt_q[c]  <= '0;
        load_q[c] <= '0;
        cmp_q[c]  <= CNT_MAX;
        ctrl_q[c] <= '0;
      end
    end else begin
      ack_q       <= access_c;
      rdat_q      <= rdat_d;
      wrap_q      <= wrap_d;
      match_q     <= match_d;
      ien_wrap_q  <= ien_wrap_d;
      ien_match_q <= ien_match_d;
      for (int c = 0; c < NUM_CNT; c++) begin
        cnt_q[c]  <= cnt_d[c];
        load_q[c] <= load_d[c];
        cmp_q[c]  <= cmp_d[c];
        ctrl_q[c] <= ctrl_d[c];
      end
    end
  end

endmodule
